// File: rtl/swap_scheduler.sv
// Swap scheduler: round-robin arbitration among four requesters for a shared
// register-file swap datapath. A granted swap runs temp<-RF[a], RF[a]<-RF[b],
// RF[b]<-temp, then pulses ack to the owner. All outputs are Moore-decoded.
module swap_scheduler #(
  parameter int ADDR_W = 3,
  parameter int NREQ   = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ*ADDR_W-1:0] addr_a,
  input  logic [NREQ*ADDR_W-1:0] addr_b,
  output logic [NREQ-1:0]        gnt,
  output logic [NREQ-1:0]        ack,
  output logic                   busy,
  output logic [1:0]             step,
  output logic [ADDR_W-1:0]      rd_addr,
  output logic [ADDR_W-1:0]      wr_addr,
  output logic                   wr_en,
  output logic                   wr_sel,
  output logic                   tmp_we
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD_T,
    MOVE_BA,
    MOVE_TB,
    ACK
  } state_t;

  state_t              state_q, state_d;
  logic [1:0]          ptr_q, ptr_d;
  logic [ADDR_W-1:0]   a_q, a_d;
  logic [ADDR_W-1:0]   b_q, b_d;
  logic [NREQ-1:0]     gnt_q, gnt_d;

  logic                win_found;
  logic [1:0]          win_idx;
  logic [1:0]          scan_idx;
  logic [ADDR_W-1:0]   win_a;
  logic [ADDR_W-1:0]   win_b;

  // Round-robin search: first requesting index at or after ptr_q, wrapping.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan_idx  = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      scan_idx = ptr_q + 2'(i);
      if (!win_found && req[scan_idx]) begin
        win_found = 1'b1;
        win_idx   = scan_idx;
      end
    end
    win_a = addr_a[win_idx*ADDR_W +: ADDR_W];
    win_b = addr_b[win_idx*ADDR_W +: ADDR_W];
  end

  // State, pointer, latched addresses and grant register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      gnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      a_q     <= a_d;
      b_q     <= b_d;
      gnt_q   <= gnt_d;
    end
  end

  // Next-state logic; inputs are only looked at in IDLE, so a dropped req or
  // changed address mid-sequence has no effect on the swap in flight.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    a_d     = a_q;
    b_d     = b_q;
    gnt_d   = gnt_q;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          gnt_d   = NREQ'(1) << win_idx;
          ptr_d   = win_idx + 2'd1;
          a_d     = win_a;
          b_d     = win_b;
          state_d = (win_a == win_b) ? ACK : LOAD_T;
        end
      end
      LOAD_T:  state_d = MOVE_BA;
      MOVE_BA: state_d = MOVE_TB;
      MOVE_TB: state_d = ACK;
      ACK: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  // Moore output decode from registered state and latched addresses.
  always_comb begin
    gnt     = gnt_q;
    ack     = '0;
    busy    = (state_q != IDLE);
    step    = 2'd0;
    rd_addr = '0;
    wr_addr = '0;
    wr_en   = 1'b0;
    wr_sel  = 1'b0;
    tmp_we  = 1'b0;
    case (state_q)
      LOAD_T: begin
        rd_addr = a_q;
        tmp_we  = 1'b1;
        step    = 2'd1;
      end
      MOVE_BA: begin
        rd_addr = b_q;
        wr_addr = a_q;
        wr_en   = 1'b1;
        step    = 2'd2;
      end
      MOVE_TB: begin
        wr_addr = b_q;
        wr_sel  = 1'b1;
        wr_en   = 1'b1;
        step    = 2'd3;
      end
      ACK: ack = gnt_q;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_swap_scheduler.sv
// Directed bench for swap_scheduler with a small register-file model
// attached to its datapath outputs.
module tb_swap_scheduler;

  localparam int AW = 3;

  logic          clk;
  logic          reset_n;
  logic [3:0]    req;
  logic [4*AW-1:0] addr_a;
  logic [4*AW-1:0] addr_b;
  logic [3:0]    gnt;
  logic [3:0]    ack;
  logic          busy;
  logic [1:0]    step;
  logic [AW-1:0] rd_addr;
  logic [AW-1:0] wr_addr;
  logic          wr_en;
  logic          wr_sel;
  logic          tmp_we;

  int checks = 0;
  int errors = 0;

  swap_scheduler #(.ADDR_W(AW), .NREQ(4)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .addr_a(addr_a), .addr_b(addr_b),
    .gnt(gnt), .ack(ack), .busy(busy), .step(step), .rd_addr(rd_addr),
    .wr_addr(wr_addr), .wr_en(wr_en), .wr_sel(wr_sel), .tmp_we(tmp_we)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file and temp register driven by the scheduler's controls.
  logic       rf_load;
  logic [3:0] rf [8];
  logic [3:0] tmp;
  logic [3:0] rd_data;
  assign rd_data = rf[rd_addr];

  always @(posedge clk) begin
    if (rf_load) begin
      for (int i = 0; i < 8; i++) rf[i] <= 4'(i);
      rf[2] <= 4'hA;
      rf[5] <= 4'hB;
      tmp   <= 4'h0;
    end else begin
      if (tmp_we) tmp <= rd_data;
      if (wr_en)  rf[wr_addr] <= wr_sel ? tmp : rd_data;
    end
  end

  int wr_cnt  = 0;
  int tmp_cnt = 0;
  always @(posedge clk) begin
    if (wr_en === 1'b1)  wr_cnt  <= wr_cnt + 1;
    if (tmp_we === 1'b1) tmp_cnt <= tmp_cnt + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_addr(input int i, input logic [AW-1:0] a, input logic [AW-1:0] b);
    addr_a[i*AW +: AW] = a;
    addr_b[i*AW +: AW] = b;
  endtask

  // Advance until an ack pulse appears (bounded), then compare it.
  task automatic wait_ack(input logic [3:0] exp, input string tag);
    int n = 0;
    while (ack === 4'b0 && n < 12) begin
      tick();
      n++;
    end
    check(tag, 32'(ack), 32'(exp));
  endtask

  int w0;
  int t0;

  initial begin
    reset_n = 1'b0;
    rf_load = 1'b1;
    req     = '0;
    addr_a  = '0;
    addr_b  = '0;
    tick();
    tick();
    rf_load = 1'b0;

    // Reset state
    check("rst_busy", 32'(busy), 0);
    check("rst_gnt", 32'(gnt), 0);
    check("rst_ack", 32'(ack), 0);
    check("rst_step", 32'(step), 0);
    check("rst_wr_en", 32'(wr_en), 0);
    check("rst_tmp_we", 32'(tmp_we), 0);
    reset_n = 1'b1;
    tick();

    // Single swap: RF[2]=A, RF[5]=B
    set_addr(0, 3'd2, 3'd5);
    req = 4'b0001;
    w0  = wr_cnt;
    tick();
    check("t1_load_step", 32'(step), 1);
    check("t1_load_gnt", 32'(gnt), 32'h1);
    check("t1_load_rd", 32'(rd_addr), 2);
    check("t1_load_tmpwe", 32'(tmp_we), 1);
    check("t1_load_wren", 32'(wr_en), 0);
    check("t1_load_busy", 32'(busy), 1);
    tick();
    check("t1_ba_step", 32'(step), 2);
    check("t1_ba_rd", 32'(rd_addr), 5);
    check("t1_ba_wr", 32'(wr_addr), 2);
    check("t1_ba_sel", 32'(wr_sel), 0);
    check("t1_ba_wren", 32'(wr_en), 1);
    tick();
    check("t1_tb_step", 32'(step), 3);
    check("t1_tb_wr", 32'(wr_addr), 5);
    check("t1_tb_sel", 32'(wr_sel), 1);
    check("t1_tb_wren", 32'(wr_en), 1);
    tick();
    check("t1_ack", 32'(ack), 32'h1);
    check("t1_ack_gnt", 32'(gnt), 32'h1);
    check("t1_ack_step", 32'(step), 0);
    check("t1_ack_wren", 32'(wr_en), 0);
    tick();
    req = '0;
    check("t1_idle_busy", 32'(busy), 0);
    check("t1_idle_gnt", 32'(gnt), 0);
    check("t1_idle_ack", 32'(ack), 0);
    check("t1_rf2", 32'(rf[2]), 32'hB);
    check("t1_rf5", 32'(rf[5]), 32'hA);
    check("t1_wr_cycles", 32'(wr_cnt - w0), 2);

    // Round robin from a fresh pointer: order 0,1,2,3
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) set_addr(i, 3'd0, 3'd0);
    req = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      wait_ack(4'(1 << i), $sformatf("rr_ack%0d", i));
      tick();
      req[i] = 1'b0;
    end
    // Pointer wrapped back to 0: requester 0 beats requester 3
    req = 4'b1001;
    tick();
    check("rr_ptr_gnt", 32'(gnt), 32'h1);
    check("rr_ptr_ack", 32'(ack), 32'h1);
    tick();
    req = 4'b1000;
    wait_ack(4'b1000, "rr_pend3");
    tick();
    req = '0;

    // Equal addresses: ack on the next cycle, no datapath activity
    set_addr(2, 3'd3, 3'd3);
    req = 4'b0100;
    w0  = wr_cnt;
    t0  = tmp_cnt;
    tick();
    check("eq_ack", 32'(ack), 32'h4);
    check("eq_step", 32'(step), 0);
    check("eq_busy", 32'(busy), 1);
    tick();
    req = '0;
    check("eq_busy_idle", 32'(busy), 0);
    check("eq_no_wr", 32'(wr_cnt - w0), 0);
    check("eq_no_tmp", 32'(tmp_cnt - t0), 0);
    check("eq_rf3", 32'(rf[3]), 3);

    // Dropped req and changed address mid-sequence are ignored
    set_addr(1, 3'd1, 3'd6);
    req = 4'b0010;
    tick();
    check("drop_gnt", 32'(gnt), 32'h2);
    check("drop_load", 32'(step), 1);
    tick();
    check("drop_ba", 32'(step), 2);
    req = '0;
    set_addr(1, 3'd7, 3'd6);
    tick();
    check("drop_tb_step", 32'(step), 3);
    check("drop_tb_wr", 32'(wr_addr), 6);
    tick();
    check("drop_ack", 32'(ack), 32'h2);
    tick();
    check("drop_rf1", 32'(rf[1]), 6);
    check("drop_rf6", 32'(rf[6]), 1);
    check("drop_rf7", 32'(rf[7]), 7);

    // Reset during MOVE_BA aborts; re-arbitration restarts at ptr 0
    set_addr(0, 3'd0, 3'd4);
    set_addr(3, 3'd2, 3'd2);
    req = 4'b0001;
    tick();
    tick();
    check("abort_ba", 32'(step), 2);
    reset_n = 1'b0;
    req = 4'b1001;
    tick();
    w0 = wr_cnt;
    check("abort_busy", 32'(busy), 0);
    check("abort_gnt", 32'(gnt), 0);
    check("abort_ack", 32'(ack), 0);
    check("abort_wren", 32'(wr_en), 0);
    reset_n = 1'b1;
    tick();
    check("abort_regnt", 32'(gnt), 32'h1);
    check("abort_no_wr", 32'(wr_cnt - w0), 0);
    wait_ack(4'b0001, "abort_ack0");
    tick();
    req = 4'b1000;
    wait_ack(4'b1000, "abort_ack3");
    tick();
    req = '0;
    check("final_busy", 32'(busy), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
